// File: rtl/clock_gate_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_gate_pkg
// Shared types and constants for the clock gate controller.
//   cg_state_t      : controller FSM state encoding (exposed on state_o)
//   DEF_*           : default timing parameters for clock_gate_ctrl
//   STATS_*_W       : widths of the optional statistics counters
//                     (present only when GATE_STATS_EN is defined)
//   drives_clk_en() : which states keep the downstream clock enabled
// -----------------------------------------------------------------------------
package clk_gate_pkg;

    typedef enum logic [2:0] {
        CG_OFF  = 3'd0,
        CG_WAKE = 3'd1,
        CG_ON   = 3'd2,
        CG_SREQ = 3'd3,
        CG_STOP = 3'd4
    } cg_state_t;

    localparam int DEF_IDLE_CYCLES = 16;
    localparam int DEF_ACK_TIMEOUT = 8;
    localparam int DEF_CNT_W       = 8;

    localparam int STATS_OFF_W  = 32;
    localparam int STATS_WAKE_W = 16;

    // The gater enable stays high from the wake request until the consumer
    // has agreed to stop; STOP drops it and then waits for the gater to follow.
    function automatic logic drives_clk_en(input cg_state_t s);
        return (s == CG_WAKE) || (s == CG_ON) || (s == CG_SREQ);
    endfunction

endpackage

// File: rtl/clock_gate_ctrl_if.sv
// -----------------------------------------------------------------------------
// clock_gate_ctrl_if
// Groups the controller's core-side and gater-side signals.
//   activity        : core has pending work this cycle
//   wake_req        : external wake request (level)
//   gated_clk_is_on : gater status, already synchronised into clk domain
//   sleep_ack       : consumer has drained and accepts sleep
//   clk_en          : enable to the clock gater
//   clk_ready       : gated clock confirmed running
//   sleep_req       : request consumer to drain
//   ack_err         : sticky gater-did-not-follow error
//   state_o         : controller FSM state
// Handshake semantics: sleep_req is a level held by the controller until the
// consumer raises sleep_ack (transfer) or new work aborts the request;
// clk_en is a level acknowledged by gated_clk_is_on following it.
// master = controller, slave = core/gater environment.
// -----------------------------------------------------------------------------
interface clock_gate_ctrl_if;
    logic       activity;
    logic       wake_req;
    logic       gated_clk_is_on;
    logic       sleep_ack;
    logic       clk_en;
    logic       clk_ready;
    logic       sleep_req;
    logic       ack_err;
    logic [2:0] state_o;

    modport master (
        input  activity, wake_req, gated_clk_is_on, sleep_ack,
        output clk_en, clk_ready, sleep_req, ack_err, state_o
    );

    modport slave (
        output activity, wake_req, gated_clk_is_on, sleep_ack,
        input  clk_en, clk_ready, sleep_req, ack_err, state_o
    );
endinterface

// File: rtl/clock_gate_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones. clr has priority over inc.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear to zero
//   inc      : increment by one unless already saturated
//   cnt      : current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clock_gate_ctrl
// Decides when a downstream clock domain is gated: idle timeout in ON raises
// sleep_req, the consumer answers with sleep_ack, then clk_en drops and the
// controller waits for the gater status to follow. Work or wake_req reopens
// the clock. All outputs are registered from the next-state value.
//
// Ports:
//   clk, rst   : free-running clock, asynchronous active-high reset
//   bus        : clock_gate_ctrl_if.master (activity, wake_req,
//                gated_clk_is_on, sleep_ack in; clk_en, clk_ready,
//                sleep_req, ack_err, state_o out)
//   off_cycles : [GATE_STATS_EN only] cycles spent in OFF, saturating
//   wake_count : [GATE_STATS_EN only] OFF->WAKE transitions, saturating
//
// Build option: define GATE_STATS_EN to add the statistics counters/ports.
// -----------------------------------------------------------------------------
module clock_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef GATE_STATS_EN
    output logic [STATS_OFF_W-1:0]   off_cycles,
    output logic [STATS_WAKE_W-1:0]  wake_count,
`endif
    clock_gate_ctrl_if.master        bus
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LIM   = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

    cg_state_t  state_q, state_d;
    logic       clk_en_q, clk_en_d;
    logic       clk_ready_q, clk_ready_d;
    logic       sleep_req_q, sleep_req_d;
    logic       ack_err_q, ack_err_d;

    logic             wake_in;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] to_cnt;
    logic             idle_inc;
    logic             to_run;

    assign wake_in = bus.activity | bus.wake_req;

    always_comb begin
        state_d  = state_q;
        idle_inc = 1'b0;
        to_run   = 1'b0;
        case (state_q)
            CG_OFF: begin
                if (wake_in) state_d = CG_WAKE;
            end
            CG_WAKE: begin
                if (bus.gated_clk_is_on) state_d = CG_ON;
                else                     to_run  = 1'b1;
            end
            CG_ON: begin
                // Idle counter holds the number of idle cycles already seen;
                // the cycle that finds IDLE_CYCLES-1 of them is the last one.
                if (!wake_in) begin
                    if (idle_cnt == IDLE_LAST) state_d  = CG_SREQ;
                    else                       idle_inc = 1'b1;
                end
            end
            CG_SREQ: begin
                // New work outranks a simultaneous sleep_ack.
                if (wake_in)            state_d = CG_ON;
                else if (bus.sleep_ack) state_d = CG_STOP;
            end
            CG_STOP: begin
                if (!bus.gated_clk_is_on) state_d = CG_OFF;
                else                      to_run  = 1'b1;
            end
            default: state_d = CG_OFF;
        endcase

        // to_run is only high while staying in WAKE/STOP, so any state change
        // clears the timeout counter. The error fires on the cycle the count
        // reaches ACK_TIMEOUT and then stays set until reset.
        ack_err_d   = ack_err_q | (to_run && (to_cnt == ACK_LAST));
        clk_en_d    = drives_clk_en(state_d);
        clk_ready_d = (state_d == CG_ON);
        sleep_req_d = (state_d == CG_SREQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CG_OFF;
            clk_en_q    <= 1'b0;
            clk_ready_q <= 1'b0;
            sleep_req_q <= 1'b0;
            ack_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_en_q    <= clk_en_d;
            clk_ready_q <= clk_ready_d;
            sleep_req_q <= sleep_req_d;
            ack_err_q   <= ack_err_d;
        end
    end

    // Idle counter: runs only on idle ON cycles, cleared otherwise so that
    // every entry into ON (including an aborted sleep) starts from zero.
    sat_counter #(.W(CNT_W)) u_idle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!idle_inc),
        .inc (idle_inc),
        .cnt (idle_cnt)
    );

    // Timeout counter: stops at ACK_TIMEOUT rather than wrapping.
    sat_counter #(.W(CNT_W)) u_to_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!to_run),
        .inc (to_run && (to_cnt != ACK_LIM)),
        .cnt (to_cnt)
    );

`ifdef GATE_STATS_EN
    sat_counter #(.W(STATS_OFF_W)) u_off_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (state_q == CG_OFF),
        .cnt (off_cycles)
    );

    sat_counter #(.W(STATS_WAKE_W)) u_wake_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc ((state_q == CG_OFF) && (state_d == CG_WAKE)),
        .cnt (wake_count)
    );
`endif

    assign bus.clk_en    = clk_en_q;
    assign bus.clk_ready = clk_ready_q;
    assign bus.sleep_req = sleep_req_q;
    assign bus.ack_err   = ack_err_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_gate_ctrl
// Bench for clock_gate_ctrl with IDLE_CYCLES=4, ACK_TIMEOUT=8. The gater is
// modelled as a two-flop follower of clk_en that can be held stuck low.
// Expected output words are {state[2:0], clk_en, clk_ready, sleep_req, ack_err}.
// -----------------------------------------------------------------------------
module tb_clock_gate_ctrl;
    import clk_gate_pkg::*;

    localparam int IDLE = 4;
    localparam int ACKT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stuck = 1'b0;
    logic [1:0] g_pipe;

    clock_gate_ctrl_if bus ();

`ifdef GATE_STATS_EN
    logic [STATS_OFF_W-1:0]  off_cycles;
    logic [STATS_WAKE_W-1:0] wake_count;
    int unsigned exp_off  = 0;
    int unsigned exp_wake = 0;
`endif

    clock_gate_ctrl #(
        .IDLE_CYCLES (IDLE),
        .ACK_TIMEOUT (ACKT),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef GATE_STATS_EN
        .off_cycles (off_cycles),
        .wake_count (wake_count),
`endif
        .bus        (bus)
    );

    // clock/reset
    always #5 clk = ~clk;

    // gater model: status follows clk_en two cycles later
    always @(posedge clk or posedge rst) begin
        if (rst) g_pipe <= 2'b00;
        else     g_pipe <= {g_pipe[0], bus.clk_en};
    end
    assign bus.gated_clk_is_on = g_pipe[1] & ~stuck;

    typedef struct {
        logic       a;
        logic       w;
        logic       sa;
        logic [6:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] model_state = 3'd0;

    function automatic logic [6:0] mk(input int st, input logic en, input logic rdy,
                                      input logic sreq, input logic err);
        logic [2:0] s;
        s = 3'(st);
        return {s, en, rdy, sreq, err};
    endfunction

    task automatic add(input logic a, input logic w, input logic sa, input int st,
                       input logic en, input logic rdy, input logic sreq);
        vec_t v;
        v.a = a; v.w = w; v.sa = sa;
        v.exp = mk(st, en, rdy, sreq, 1'b0);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, want);
        end
    endtask

    // driver + scoreboard: drive one cycle, push expectation, compare after edge
    task automatic do_step(input string name, input int idx, input logic a,
                           input logic w, input logic sa, input logic [6:0] exp);
        logic [6:0] got;
        logic [6:0] want;
        bus.activity  = a;
        bus.wake_req  = w;
        bus.sleep_ack = sa;
        exp_q.push_back(exp);
`ifdef GATE_STATS_EN
        if (model_state == 3'd0) exp_off++;
        if (model_state == 3'd0 && exp[6:4] == 3'd1) exp_wake++;
`endif
        model_state = exp[6:4];
        @(negedge clk);
        got  = {bus.state_o, bus.clk_en, bus.clk_ready, bus.sleep_req, bus.ack_err};
        want = exp_q.pop_front();
        check(name, idx, 32'(got), 32'(want));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        stuck = 1'b0;
        bus.activity  = 1'b0;
        bus.wake_req  = 1'b0;
        bus.sleep_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_state = 3'd0;
`ifdef GATE_STATS_EN
        exp_off  = 0;
        exp_wake = 0;
`endif
    endtask

    task automatic check_reset_state(input string name);
        check(name, 0, 32'({bus.state_o, bus.clk_en, bus.clk_ready, bus.sleep_req,
                            bus.ack_err}), 32'd0);
    endtask

    task automatic check_stats(input int idx);
`ifdef GATE_STATS_EN
        check("off_cycles", idx, off_cycles, exp_off);
        check("wake_count", idx, 32'(wake_count), exp_wake);
`else
        n_tests = n_tests + 0 * idx;
`endif
    endtask

    initial begin
        bus.activity  = 1'b0;
        bus.wake_req  = 1'b0;
        bus.sleep_ack = 1'b0;

        // wake, gater ack, idle timeout, sleep handshake, abort and STOP wake
        add(0,0,0, 0,0,0,0); add(0,0,0, 0,0,0,0);
        add(0,1,0, 1,1,0,0); add(0,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0);
        add(0,0,0, 2,1,1,0);
        add(1,0,0, 2,1,1,0); add(1,0,0, 2,1,1,0);
        add(0,0,0, 2,1,1,0); add(0,0,0, 2,1,1,0); add(0,0,0, 2,1,1,0);
        add(0,0,0, 3,1,0,1); add(0,0,0, 3,1,0,1);
        add(0,0,1, 4,0,0,0); add(0,0,0, 4,0,0,0); add(0,0,0, 4,0,0,0);
        add(0,0,0, 0,0,0,0); add(0,0,0, 0,0,0,0);
        add(1,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0);
        add(0,0,0, 2,1,1,0);
        add(0,0,0, 2,1,1,0); add(0,0,0, 2,1,1,0); add(0,0,0, 2,1,1,0);
        add(0,0,0, 3,1,0,1);
        add(1,0,1, 2,1,1,0);
        add(0,0,0, 2,1,1,0); add(0,0,0, 2,1,1,0); add(0,0,0, 2,1,1,0);
        add(0,0,0, 3,1,0,1);
        add(0,1,0, 2,1,1,0);
        add(0,0,0, 2,1,1,0); add(0,0,0, 2,1,1,0); add(0,0,0, 2,1,1,0);
        add(0,0,0, 3,1,0,1);
        add(0,0,1, 4,0,0,0);
        add(0,1,0, 4,0,0,0); add(0,1,0, 4,0,0,0);
        add(0,1,0, 0,0,0,0);
        add(0,1,0, 1,1,0,0);
        add(0,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0);
        add(0,0,0, 2,1,1,0);

        apply_reset();
        check_reset_state("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            do_step("vec", i, vecs[i].a, vecs[i].w, vecs[i].sa, vecs[i].exp);
        end
        check_stats(0);

        // asynchronous reset while ON: outputs must fall before any clock edge
        rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        apply_reset();

        // gater never follows: ack_err after 8 WAKE cycles, sticky thereafter
        stuck = 1'b1;
        do_step("ack_to", 0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 0, 0));
        for (int j = 1; j <= 10; j++) begin
            do_step("ack_to", j, 1'b0, 1'b0, 1'b0, mk(1, 1, 0, 0, (j >= ACKT)));
        end
        stuck = 1'b0;
        do_step("ack_sticky", 0, 1'b0, 1'b0, 1'b0, mk(2, 1, 1, 0, 1));
        do_step("ack_sticky", 1, 1'b1, 1'b0, 1'b0, mk(2, 1, 1, 0, 1));
        check_stats(1);

        apply_reset();
        check_reset_state("reset_clears_err");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
